mig_axi_slice_limiter: RTL and testbench

- Registered AXI4 pipeline stage between the chip-top MIG AXI master port and the MIG AXI slave port, in the mig_ui_clk domain.
- Each of the five channels (AW, W, AR, B, R) passes through a 2-entry skid buffer, which breaks every valid and ready timing path.
- Caps outstanding write and read bursts so the MIG command queue cannot be oversubscribed.

---
 rtl/mig_axi_slice_limiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_mig_axi_slice_limiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mig_axi_slice_limiter.sv
// Registered AXI4 slice between the MIG AXI master and slave ports, with outstanding-burst caps.
// Define MIG_AXI_SLICE_STATS_EN to add the stat_* burst/stall counters.

module mig_axi_slice_limiter_skid #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         out_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic         skid_valid;
    logic [W-1:0] skid_data;
    logic         in_fire;
    logic         advance;

    assign in_fire = in_valid && in_ready;
    // out_valid is the raw main-register state; out_en gates only what is presented downstream
    assign advance = !out_valid || (out_en && out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else if (advance) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                out_valid <= in_fire;
                if (in_fire) begin
                    out_data <= in_data;
                end
            end
            in_ready <= 1'b1;
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
            in_ready   <= 1'b0;
        end else begin
            in_ready <= !skid_valid;
        end
    end
endmodule

module mig_axi_slice_limiter #(
    parameter int unsigned ID_W       = 4,
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MAX_WR_OUT = 8,
    parameter int unsigned MAX_RD_OUT = 8
) (
    input  logic                  mig_ui_clk,
    input  logic                  mig_ui_rst,
`ifdef MIG_AXI_SLICE_STATS_EN
    output logic [31:0]           stat_wr_bursts,
    output logic [31:0]           stat_rd_bursts,
    output logic [31:0]           stat_wr_stall_cycles,
`endif
    input  logic [ID_W-1:0]       s_axi_awid,
    input  logic [ADDR_W-1:0]     s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awlock,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_W-1:0]     s_axi_wdata,
    input  logic [DATA_W/8-1:0]   s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_W-1:0]       s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_W-1:0]       s_axi_arid,
    input  logic [ADDR_W-1:0]     s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_W-1:0]       s_axi_rid,
    output logic [DATA_W-1:0]     s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ID_W-1:0]       m_axi_awid,
    output logic [ADDR_W-1:0]     m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [DATA_W-1:0]     m_axi_wdata,
    output logic [DATA_W/8-1:0]   m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [ID_W-1:0]       m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [ID_W-1:0]       m_axi_arid,
    output logic [ADDR_W-1:0]     m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_W-1:0]       m_axi_rid,
    input  logic [DATA_W-1:0]     m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);
    localparam int unsigned AX_W = ID_W + ADDR_W + 25;
    localparam int unsigned WD_W = DATA_W + DATA_W/8 + 1;
    localparam int unsigned B_W  = ID_W + 2;
    localparam int unsigned R_W  = ID_W + DATA_W + 3;

    logic [AX_W-1:0] aw_in, aw_out, ar_in, ar_out;
    logic [WD_W-1:0] w_in, w_out;
    logic [B_W-1:0]  b_in, b_out;
    logic [R_W-1:0]  r_in, r_out;
    logic            aw_main_valid, ar_main_valid;
    logic            wr_at_cap, rd_at_cap;
    logic            aw_fire, b_fire, ar_fire, r_last_fire;
    logic [7:0]      wr_cnt, rd_cnt;

    assign aw_in = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                    s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos};
    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos} = aw_out;
    assign ar_in = {s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                    s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos};
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos} = ar_out;
    assign w_in = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_out;
    assign b_in = {m_axi_bid, m_axi_bresp};
    assign {s_axi_bid, s_axi_bresp} = b_out;
    assign r_in = {m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast};
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out;

    assign wr_at_cap     = (wr_cnt == 8'(MAX_WR_OUT));
    assign rd_at_cap     = (rd_cnt == 8'(MAX_RD_OUT));
    assign m_axi_awvalid = aw_main_valid && !wr_at_cap;
    assign m_axi_arvalid = ar_main_valid && !rd_at_cap;

    assign aw_fire     = m_axi_awvalid && m_axi_awready;
    assign b_fire      = s_axi_bvalid && s_axi_bready;
    assign ar_fire     = m_axi_arvalid && m_axi_arready;
    assign r_last_fire = s_axi_rvalid && s_axi_rready && s_axi_rlast;

    mig_axi_slice_limiter_skid #(.W(AX_W)) u_aw (
        .clk(mig_ui_clk), .rst(mig_ui_rst),
        .in_valid(s_axi_awvalid), .in_ready(s_axi_awready), .in_data(aw_in),
        .out_en(!wr_at_cap), .out_valid(aw_main_valid), .out_ready(m_axi_awready), .out_data(aw_out)
    );

    mig_axi_slice_limiter_skid #(.W(WD_W)) u_w (
        .clk(mig_ui_clk), .rst(mig_ui_rst),
        .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data(w_in),
        .out_en(1'b1), .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out)
    );

    mig_axi_slice_limiter_skid #(.W(B_W)) u_b (
        .clk(mig_ui_clk), .rst(mig_ui_rst),
        .in_valid(m_axi_bvalid), .in_ready(m_axi_bready), .in_data(b_in),
        .out_en(1'b1), .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out)
    );

    mig_axi_slice_limiter_skid #(.W(AX_W)) u_ar (
        .clk(mig_ui_clk), .rst(mig_ui_rst),
        .in_valid(s_axi_arvalid), .in_ready(s_axi_arready), .in_data(ar_in),
        .out_en(!rd_at_cap), .out_valid(ar_main_valid), .out_ready(m_axi_arready), .out_data(ar_out)
    );

    mig_axi_slice_limiter_skid #(.W(R_W)) u_r (
        .clk(mig_ui_clk), .rst(mig_ui_rst),
        .in_valid(m_axi_rvalid), .in_ready(m_axi_rready), .in_data(r_in),
        .out_en(1'b1), .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out)
    );

    // A completion with nothing outstanding is a protocol error: hold at 0, still forward it
    always_ff @(posedge mig_ui_clk or posedge mig_ui_rst) begin
        if (mig_ui_rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (aw_fire && !b_fire) begin
                wr_cnt <= wr_cnt + 8'd1;
            end else if (b_fire && !aw_fire && wr_cnt != 8'd0) begin
                wr_cnt <= wr_cnt - 8'd1;
            end
            if (ar_fire && !r_last_fire) begin
                rd_cnt <= rd_cnt + 8'd1;
            end else if (r_last_fire && !ar_fire && rd_cnt != 8'd0) begin
                rd_cnt <= rd_cnt - 8'd1;
            end
        end
    end

`ifdef MIG_AXI_SLICE_STATS_EN
    always_ff @(posedge mig_ui_clk or posedge mig_ui_rst) begin
        if (mig_ui_rst) begin
            stat_wr_bursts       <= '0;
            stat_rd_bursts       <= '0;
            stat_wr_stall_cycles <= '0;
        end else begin
            if (aw_fire) begin
                stat_wr_bursts <= stat_wr_bursts + 32'd1;
            end
            if (ar_fire) begin
                stat_rd_bursts <= stat_rd_bursts + 32'd1;
            end
            if (aw_main_valid && wr_at_cap) begin
                stat_wr_stall_cycles <= stat_wr_stall_cycles + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mig_axi_slice_limiter.sv
// Directed bench for mig_axi_slice_limiter (write cap 2, read cap 8) with a small MIG read model.
// Inputs change on the falling edge; outputs are sampled between falling and rising edges.

module tb_mig_axi_slice_limiter;
    localparam int unsigned RD_LAT = 12;

    logic clk = 1'b0;
    logic mig_ui_rst;
`ifdef MIG_AXI_SLICE_STATS_EN
    logic [31:0] stat_wr_bursts, stat_rd_bursts, stat_wr_stall_cycles;
`endif
    logic [3:0]  s_axi_awid;    logic [29:0] s_axi_awaddr;  logic [7:0] s_axi_awlen;
    logic [2:0]  s_axi_awsize;  logic [1:0]  s_axi_awburst; logic       s_axi_awlock;
    logic [3:0]  s_axi_awcache; logic [2:0]  s_axi_awprot;  logic [3:0] s_axi_awqos;
    logic        s_axi_awvalid, s_axi_awready;
    logic [63:0] s_axi_wdata;   logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic [3:0]  s_axi_bid;     logic [1:0]  s_axi_bresp;   logic s_axi_bvalid, s_axi_bready;
    logic [3:0]  s_axi_arid;    logic [29:0] s_axi_araddr;  logic [7:0] s_axi_arlen;
    logic [2:0]  s_axi_arsize;  logic [1:0]  s_axi_arburst; logic       s_axi_arlock;
    logic [3:0]  s_axi_arcache; logic [2:0]  s_axi_arprot;  logic [3:0] s_axi_arqos;
    logic        s_axi_arvalid, s_axi_arready;
    logic [3:0]  s_axi_rid;     logic [63:0] s_axi_rdata;   logic [1:0] s_axi_rresp;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
    logic [3:0]  m_axi_awid;    logic [29:0] m_axi_awaddr;  logic [7:0] m_axi_awlen;
    logic [2:0]  m_axi_awsize;  logic [1:0]  m_axi_awburst; logic       m_axi_awlock;
    logic [3:0]  m_axi_awcache; logic [2:0]  m_axi_awprot;  logic [3:0] m_axi_awqos;
    logic        m_axi_awvalid, m_axi_awready;
    logic [63:0] m_axi_wdata;   logic [7:0]  m_axi_wstrb;
    logic        m_axi_wlast, m_axi_wvalid, m_axi_wready;
    logic [3:0]  m_axi_bid;     logic [1:0]  m_axi_bresp;   logic m_axi_bvalid, m_axi_bready;
    logic [3:0]  m_axi_arid;    logic [29:0] m_axi_araddr;  logic [7:0] m_axi_arlen;
    logic [2:0]  m_axi_arsize;  logic [1:0]  m_axi_arburst; logic       m_axi_arlock;
    logic [3:0]  m_axi_arcache; logic [2:0]  m_axi_arprot;  logic [3:0] m_axi_arqos;
    logic        m_axi_arvalid, m_axi_arready;
    logic [3:0]  m_axi_rid = '0;
    logic [63:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rlast = 1'b0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;

    mig_axi_slice_limiter #(
        .ID_W(4), .ADDR_W(30), .DATA_W(64), .MAX_WR_OUT(2), .MAX_RD_OUT(8)
    ) dut (
        .mig_ui_clk(clk), .mig_ui_rst(mig_ui_rst),
`ifdef MIG_AXI_SLICE_STATS_EN
        .stat_wr_bursts(stat_wr_bursts), .stat_rd_bursts(stat_rd_bursts),
        .stat_wr_stall_cycles(stat_wr_stall_cycles),
`endif
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
        .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot), .s_axi_awqos(s_axi_awqos),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
        .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot), .s_axi_arqos(s_axi_arqos),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Handshake monitor plus MIG read model: R beats return RD_LAT cycles after their AR
    int unsigned cyc = 0;
    int unsigned aw_hs = 0, ar_hs = 0, rl_hs = 0, rd_out_max = 0;
    int unsigned ar_cyc [$];
    int unsigned rl_cyc [$];
    int unsigned rq_time [$];
    logic [3:0]  rq_id [$];
    logic        r_fire_q = 1'b0;
    logic [3:0]  exp_rid = '0;

    always begin
        @(negedge clk);
        cyc++;
        if (r_fire_q) begin
            rq_time.delete(0);
            rq_id.delete(0);
        end
        if (rq_time.size() > 0 && cyc >= rq_time[0]) begin
            m_axi_rvalid = 1'b1;
            m_axi_rid    = rq_id[0];
            m_axi_rdata  = 64'h5A00 + 64'(rq_id[0]);
            m_axi_rlast  = 1'b1;
        end else begin
            m_axi_rvalid = 1'b0;
        end
        #2;
        r_fire_q = m_axi_rvalid && m_axi_rready;
        if (m_axi_awvalid && m_axi_awready) aw_hs++;
        if (m_axi_arvalid && m_axi_arready) begin
            ar_hs++;
            ar_cyc.push_back(cyc);
            rq_time.push_back(cyc + RD_LAT);
            rq_id.push_back(m_axi_arid);
        end
        if (s_axi_rvalid && s_axi_rready && s_axi_rlast) begin
            check_val("rd_rid_order", 64'(s_axi_rid), 64'(exp_rid));
            exp_rid++;
            rl_hs++;
            rl_cyc.push_back(cyc);
        end
        if (ar_hs - rl_hs > rd_out_max) rd_out_max = ar_hs - rl_hs;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_aw(input logic [3:0] id, input logic [29:0] addr, input logic [7:0] len);
        s_axi_awvalid = 1'b1;
        s_axi_awid    = id;
        s_axi_awaddr  = addr;
        s_axi_awlen   = len;
        @(negedge clk);
    endtask

    int unsigned aw_base, to, tx, rx, gaps, werr;

    initial begin
        mig_ui_rst    = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
        s_axi_awburst = 2'd1; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
        s_axi_awqos = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
        s_axi_arburst = 2'd1; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
        s_axi_arqos = '0; s_axi_arvalid = 1'b0;
        s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check_val("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid}, 5'h00);
        check_val("rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 5'h00);
        check_val("rst_payload", {m_axi_awaddr, m_axi_wstrb, s_axi_bid}, '0);
        mig_ui_rst = 1'b0;
        @(negedge clk);
        check_val("rst_rel_readies", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 5'h1f);

        // single write: AW, 4 W beats, one B
        send_aw(4'h3, 30'h0000_1000, 8'd3);
        s_axi_awvalid = 1'b0;
        check_val("wr1_awvalid", m_axi_awvalid, 1'b1);
        check_val("wr1_awaddr", m_axi_awaddr, 30'h0000_1000);
        check_val("wr1_awlen_id", {m_axi_awid, m_axi_awlen}, 12'h303);
        for (int k = 0; k < 4; k++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = 64'hD000_0000_0000_0000 + 64'(k);
            s_axi_wstrb  = 8'hF0 | 8'(k);
            s_axi_wlast  = (k == 3);
            @(negedge clk);
            check_val("wr1_wdata", m_axi_wdata, 64'hD000_0000_0000_0000 + 64'(k));
            check_val("wr1_wctl", {m_axi_wvalid, m_axi_wlast, m_axi_wstrb}, {1'b1, 1'(k == 3), 8'hF0 | 8'(k)});
        end
        s_axi_wvalid = 1'b0;
        m_axi_bvalid = 1'b1; m_axi_bid = 4'h3; m_axi_bresp = 2'd0;
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        check_val("wr1_b", {s_axi_bvalid, s_axi_bid, s_axi_bresp}, {1'b1, 4'h3, 2'd0});
        check_val("wr1_cnt_busy", 64'(dut.wr_cnt), 64'd1);
        @(negedge clk);
        check_val("wr1_cnt_idle", 64'(dut.wr_cnt), 64'd0);

        // write cap of 2: third AW held until the first B returns upstream
        aw_base = aw_hs;
        for (int k = 0; k < 3; k++) send_aw(4'(k), 30'h2000 + 30'(k * 256), 8'd0);
        s_axi_awvalid = 1'b0;
        repeat (5) @(negedge clk);
        check_val("lim_aw_hs", 64'(aw_hs - aw_base), 64'd2);
        check_val("lim_held", {m_axi_awvalid, m_axi_awaddr}, {1'b0, 30'h2200});
        m_axi_bvalid = 1'b1; m_axi_bid = 4'h0;
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        check_val("lim_b_pending", {s_axi_bvalid, m_axi_awvalid}, 2'b10);
        @(negedge clk);
        check_val("lim_release", {m_axi_awvalid, m_axi_awaddr}, {1'b1, 30'h2200});

        // same-cycle AW issue and B return leave the count unchanged
        send_aw(4'h3, 30'h2300, 8'd0);
        s_axi_awvalid = 1'b0;
        @(negedge clk);
        check_val("sim_held", {m_axi_awvalid, m_axi_awaddr}, {1'b0, 30'h2300});
        m_axi_bvalid = 1'b1; m_axi_bid = 4'h1;
        @(negedge clk);
        m_axi_bid = 4'h2;
        @(negedge clk);
        m_axi_bvalid = 1'b0;
        check_val("sim_both_valid", {m_axi_awvalid, s_axi_bvalid}, 2'b11);
        @(negedge clk);
        check_val("sim_cnt", 64'(dut.wr_cnt), 64'd1);
        aw_base = aw_hs;
        send_aw(4'h4, 30'h2400, 8'd0);
        send_aw(4'h5, 30'h2500, 8'd0);
        s_axi_awvalid = 1'b0;
        repeat (5) @(negedge clk);
        check_val("sim_aw_hs", 64'(aw_hs - aw_base), 64'd1);
        check_val("sim_after", {m_axi_awvalid, m_axi_awaddr}, {1'b0, 30'h2500});

        // 16 back-to-back single-beat reads against an 8-deep cap
        to = 0;
        for (int i = 0; i < 16; i++) begin
            s_axi_arvalid = 1'b1;
            s_axi_arid    = 4'(i);
            s_axi_araddr  = 30'h4000 + 30'(i * 64);
            s_axi_arlen   = 8'd0;
            #1;
            while (!s_axi_arready && to < 400) begin
                @(negedge clk);
                #1;
                to++;
            end
            @(negedge clk);
        end
        s_axi_arvalid = 1'b0;
        while (rl_hs < 16 && to < 800) begin
            @(negedge clk);
            to++;
        end
        check_val("rd_ar_hs", 64'(ar_hs), 64'd16);
        check_val("rd_r_last_hs", 64'(rl_hs), 64'd16);
        check_val("rd_out_max", 64'(rd_out_max), 64'd8);
        if (ar_cyc.size() >= 9 && rl_cyc.size() >= 1) begin
            check_val("rd_first8_consec", 64'(ar_cyc[7] - ar_cyc[0]), 64'd7);
            check_val("rd_resume", 64'(ar_cyc[8]), 64'(rl_cyc[0] + 1));
        end else begin
            check_val("rd_hs_recorded", 64'(ar_cyc.size()), 64'd16);
        end

        // W backpressure: 1000 incrementing beats, random downstream ready
        tx = 0; rx = 0; gaps = 0; werr = 0; to = 0;
        while (rx < 1000 && to < 20000) begin
            m_axi_wready = 1'($urandom_range(0, 1));
            s_axi_wvalid = (tx < 1000);
            s_axi_wdata  = {32'(tx), ~32'(tx)};
            s_axi_wstrb  = 8'(tx);
            s_axi_wlast  = ((tx % 4) == 3);
            #1;
            if (m_axi_wvalid && m_axi_wready) begin
                if (m_axi_wdata != {32'(rx), ~32'(rx)} || m_axi_wstrb != 8'(rx) ||
                    m_axi_wlast != ((rx % 4) == 3)) werr++;
                rx++;
            end else if (!m_axi_wvalid && rx > 0) begin
                gaps++;
            end
            if (s_axi_wvalid && s_axi_wready) tx++;
            @(negedge clk);
            to++;
        end
        s_axi_wvalid = 1'b0;
        m_axi_wready = 1'b1;
        check_val("bp_beats", 64'(rx), 64'd1000);
        check_val("bp_order_errs", 64'(werr), 64'd0);
        check_val("bp_gaps", 64'(gaps), 64'd0);

`ifdef MIG_AXI_SLICE_STATS_EN
        check_val("stat_wr_bursts", 64'(stat_wr_bursts), 64'(aw_hs));
        check_val("stat_rd_bursts", 64'(stat_rd_bursts), 64'd16);
`endif

        // reset asserted mid-burst, between edges
        for (int k = 0; k < 2; k++) begin
            s_axi_wvalid = 1'b1;
            s_axi_wdata  = 64'hBEEF_0000 + 64'(k);
            s_axi_wlast  = 1'b0;
            @(negedge clk);
        end
        s_axi_wdata = 64'hBEEF_0002;
        check_val("mid_pre_wvalid", {m_axi_wvalid, m_axi_wdata}, {1'b1, 64'hBEEF_0001});
        #3;
        mig_ui_rst = 1'b1;
        #1;
        check_val("mid_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, s_axi_bvalid, s_axi_rvalid}, 5'h00);
        check_val("mid_readies", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 5'h00);
        check_val("mid_payload", m_axi_wdata, 64'h0);
        check_val("mid_wr_cnt", 64'(dut.wr_cnt), 64'd0);
`ifdef MIG_AXI_SLICE_STATS_EN
        check_val("mid_stat_wr", 64'(stat_wr_bursts), 64'd0);
`endif
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        mig_ui_rst = 1'b0;
        @(negedge clk);
        check_val("mid_rel_readies", {s_axi_awready, s_axi_wready, s_axi_arready, m_axi_bready, m_axi_rready}, 5'h1f);
        check_val("mid_rel_wvalid", m_axi_wvalid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
